// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
//   Bundles the serial line and the downstream valid/ready word interface of
//   the UART receiver.
//
//   Signals:
//     rx          serial line into the receiver (idles high)
//     data_out    last received word, stable while data_valid=1
//     data_valid  an unconsumed word is on data_out
//     data_ready  consumer accepts the word this cycle
//     frame_err   one-cycle pulse: stop bit sampled low
//     overrun     one-cycle pulse: good frame dropped, previous word unconsumed
//     rx_busy     receiver state machine is not idle
//
//   Modports:
//     master  the receiver side (drives the word interface)
//     slave   the line driver / consumer side
// ----------------------------------------------------------------------------
interface uart_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  frame_err;
    logic                  overrun;
    logic                  rx_busy;

    modport master (
        input  rx,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output rx_busy
    );

    modport slave (
        output rx,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   Oversampling UART receiver. The line is synchronised with two flops, the
//   start bit is validated at mid-bit, then data bits (LSB first) and the stop
//   bit are sampled at mid-bit. Received words are offered on a valid/ready
//   interface with framing-error and overrun pulses.
//
//   Parameters:
//     CLOCKS_PER_PULSE  clocks per bit period (even, >= 4)
//     DATA_WIDTH        data bits per frame (>= 2)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   uart_receiver_if.master (rx, data_ready in; data_out, data_valid,
//           frame_err, overrun, rx_busy out)
// ----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int DATA_WIDTH       = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_receiver_if.master   bus
);
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  r_rx_busy;

    logic                  w_xfer;

    assign w_xfer = r_data_valid & bus.data_ready;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, exactly like real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            // NOTE: synchroniser flops reset to the idle line level so the
            // FSM cannot see a false start edge as reset releases.
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_rx_meta   <= bus.rx;
            r_rx_s      <= r_rx_meta;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // A load in STOP below overrides this clear.
            if (w_xfer) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                        r_rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_clk_cnt <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            // Start bit did not hold to mid-bit: glitch.
                            r_state   <= S_IDLE;
                            r_rx_busy <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        // LSB arrives first, so shifting right leaves the
                        // word LSB-aligned after the last data bit.
                        r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_rx_s) begin
                            if (!r_data_valid || w_xfer) begin
                                r_data_out   <= r_shift;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            // Leaving at mid-stop lets a back-to-back start
                            // edge be caught on time.
                            r_state   <= S_IDLE;
                            r_rx_busy <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_RECOVER;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_RECOVER: begin
                    // Wait out a break so it yields only one frame_err.
                    if (r_rx_s) begin
                        r_state   <= S_IDLE;
                        r_rx_busy <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.rx_busy    = r_rx_busy;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial receiver that consumes the single-wire line driven by the team's UART transmitter and recovers parallel bytes.
- Oversamples the line at CLOCKS_PER_PULSE clocks per bit, validates the start bit at mid-bit and samples data and stop bits at mid-bit.
- Presents each received word on a valid/ready interface to the downstream bus logic, with framing-error and overrun reporting.

Parameters:
- CLOCKS_PER_PULSE, 16: clocks per bit period; must be even and >= 4; must match the transmitter setting.
- DATA_WIDTH, 8: data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  DATA_WIDTH  last received word; held stable while data_valid=1.
- data_valid  output  1  high while data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts; a transfer occurs on a cycle with data_valid & data_ready.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- overrun  output  1  one-cycle pulse when a good frame completes while the previous word is still unconsumed.
- rx_busy  output  1  high when the state machine is not IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge): state=IDLE; counters=0; shift register=0; data_out=0; data_valid=0; frame_err=0; overrun=0; rx_busy=0; synchroniser flops=1.
- Reset mid-frame aborts the frame with no output pulse.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Clock counter width is $clog2(CLOCKS_PER_PULSE). Bit counter width is $clog2(DATA_WIDTH)+1.
- IDLE: when rx_s=0, go to START with clock counter=0.
- START: count to CLOCKS_PER_PULSE/2-1, then sample rx_s.
  - rx_s=0: go to DATA, clock counter=0, bit counter=0.
  - rx_s=1: glitch; return to IDLE with no output.
- DATA: at clock counter=CLOCKS_PER_PULSE-1, sample rx_s.
  - Shift right into the shift register (new bit enters the MSB), so the word ends LSB-aligned after DATA_WIDTH samples.
  - Reset the clock counter and increment the bit counter.
  - After the DATA_WIDTH-th sample, go to STOP.
- STOP: at clock counter=CLOCKS_PER_PULSE-1, sample rx_s.
  - rx_s=1, data_valid=0 (or being consumed this cycle): load data_out from the shift register; data_valid=1 next cycle; go to IDLE.
  - rx_s=1, data_valid=1 and not consumed this cycle: keep the old data_out; drop the new word; pulse overrun; go to IDLE.
  - rx_s=0: pulse frame_err; discard the word; go to RECOVER.
- RECOVER: wait until rx_s=1, then go to IDLE. A held-low line (break) produces exactly one frame_err and no further frames.
- data_valid clears on the cycle after a transfer.
  - If a load and a transfer occur in the same cycle, the load wins: data_valid stays 1 with the new data.
- Timing: data_valid rises 2 + CLOCKS_PER_PULSE/2 + (DATA_WIDTH+1)*CLOCKS_PER_PULSE clocks (±2) after rx falls at the start edge.
- Returning to IDLE at mid-stop allows a back-to-back start bit to be caught with no lost frame.
- Illegal state encoding recovers to IDLE on the next clock.

Test Plan:
- Loopback with the transmitter (CLOCKS_PER_PULSE=16) sending 0xA5, data_ready=1 -> data_out=0xA5; data_valid high exactly 1 cycle; frame_err=0; overrun=0; data_valid at 154±2 clocks after the start edge.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap, data_ready=1 -> three valid words in order, no errors.
- rx low for 4 clocks then high -> no data_valid, no frame_err; rx_busy returns to 0 within 12 clocks of the falling edge.
- Frame 0x5A with the stop bit forced 0, then line high -> frame_err pulses once; data_valid stays 0; next frame 0x11 is received correctly.
- data_ready=0, send 0x12 then 0x34 -> data_out stays 0x12 with data_valid=1; overrun pulses at the second stop bit; raising data_ready consumes 0x12 and data_valid drops.
- rst=1 for 1 cycle in the middle of the DATA state of a 0x77 frame -> all outputs go to their reset values; the partial frame is not delivered; a subsequent 0x77 frame is received correctly.
